// File: rtl/stream_pkt_gen.sv
// stream_pkt_gen: AXI-Stream packet transmitter. Emits a programmed number of
// fixed-length packets on a 512-bit stream with byte-accurate keep/last,
// inserts a programmable idle gap between packets, honours backpressure and
// reports transmitted packet/byte totals.
//
// Build option: define STREAM_PKT_GEN_LFSR_EN to source payload from one
// 32-bit Galois LFSR per lane; otherwise a counting pattern is emitted.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           pulse; latches num_pkts/pkt_len/gap and starts a run
//   stop            level; ends the run at the next packet boundary
//   num_pkts        packets per run (0 = until stop)
//   pkt_len         packet length in bytes
//   gap             idle cycles between packets
//   tx_valid/tx_data/tx_keep/tx_last/tx_ready   AXI-Stream source
//   busy            run in progress
//   done            one-cycle pulse at end of run
//   sent_pkts       packets completed this run
//   sent_bytes      bytes completed this run
module stream_pkt_gen #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned GAP_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         num_pkts,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic [GAP_W-1:0]    gap,
  output logic                tx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic [DATA_W/8-1:0] tx_keep,
  output logic                tx_last,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         sent_pkts,
  output logic [63:0]         sent_bytes
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned LANES  = DATA_W / 32;
  localparam int unsigned BEAT_W = LEN_W - 6 + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FIN} state_t;

  state_t              r_state, w_state_nx;
  logic [31:0]         r_num_pkts, w_num_nx;
  logic [5:0]          r_rem, w_rem_nx;
  logic [GAP_W-1:0]    r_gap, w_gap_nx;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_nx;
  logic [BEAT_W-1:0]   r_last_idx, w_last_idx_nx;
  logic [BEAT_W-1:0]   r_beat, w_beat_nx;
  logic                r_tx_valid, w_valid_nx;
  logic [DATA_W-1:0]   r_tx_data, w_data_nx;
  logic [KEEP_W-1:0]   r_tx_keep, w_keep_nx;
  logic                r_tx_last, w_last_nx;
  logic                r_busy, w_busy_nx;
  logic                r_done, w_done_nx;
  logic [31:0]         r_sent_pkts, w_pkts_nx;
  logic [63:0]         r_sent_bytes, w_bytes_nx;

  logic                w_acc;
  logic                w_end;
  logic                w_ld;
  logic [15:0]         w_ld_idx;
  logic [BEAT_W-1:0]   w_ld_beat;

`ifdef STREAM_PKT_GEN_LFSR_EN
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  logic [DATA_W-1:0]   r_lfsr, w_lfsr_nx;
`endif

  assign w_acc = r_tx_valid & tx_ready;
  // Run ends after this packet if the count is reached or stop is requested
  assign w_end = ((r_num_pkts != 32'd0) && ((r_sent_pkts + 32'd1) == r_num_pkts)) || stop;

  // Byte enables: only the final beat of a packet can be partial
  function automatic logic [KEEP_W-1:0] keep_for(input logic [BEAT_W-1:0] beat,
                                                 input logic [BEAT_W-1:0] last_idx,
                                                 input logic [5:0]        rem);
    if ((beat == last_idx) && (rem != 6'd0))
      keep_for = (KEEP_W'(1) << rem) - KEEP_W'(1);
    else
      keep_for = '1;
  endfunction

  // Zero every byte lane that is not enabled
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [KEEP_W-1:0] k);
    for (int j = 0; j < KEEP_W; j++)
      mask_bytes[j*8 +: 8] = k[j] ? d[j*8 +: 8] : 8'h00;
  endfunction

`ifdef STREAM_PKT_GEN_LFSR_EN
  // Right-shifting Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_seed(input logic [15:0] idx);
    for (int i = 0; i < LANES; i++)
      lfsr_seed[i*32 +: 32] = {idx, 12'h000, 4'(i)} ^ 32'hA5A5_A5A5;
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_adv(input logic [DATA_W-1:0] v);
    for (int i = 0; i < LANES; i++)
      lfsr_adv[i*32 +: 32] = lfsr_step(v[i*32 +: 32]);
  endfunction
`else
  // Counting pattern: lane i = {pkt_idx, beat, lane}
  function automatic logic [DATA_W-1:0] count_pat(input logic [15:0]       idx,
                                                  input logic [BEAT_W-1:0] beat);
    for (int i = 0; i < LANES; i++)
      count_pat[i*32 +: 32] = {idx, 12'(beat), 4'(i)};
  endfunction
`endif

  // Next-state and next-output logic
  always_comb begin
    w_state_nx    = r_state;
    w_num_nx      = r_num_pkts;
    w_rem_nx      = r_rem;
    w_gap_nx      = r_gap;
    w_gap_cnt_nx  = r_gap_cnt;
    w_last_idx_nx = r_last_idx;
    w_beat_nx     = r_beat;
    w_valid_nx    = r_tx_valid;
    w_data_nx     = r_tx_data;
    w_keep_nx     = r_tx_keep;
    w_last_nx     = r_tx_last;
    w_busy_nx     = r_busy;
    w_done_nx     = 1'b0;
    w_pkts_nx     = r_sent_pkts;
    w_bytes_nx    = r_sent_bytes;
    w_ld          = 1'b0;
    w_ld_idx      = r_sent_pkts[15:0];
    w_ld_beat     = '0;
`ifdef STREAM_PKT_GEN_LFSR_EN
    w_lfsr_nx     = r_lfsr;
`endif

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pkts_nx  = '0;
          w_bytes_nx = '0;
          if (pkt_len == '0) begin
            w_state_nx = S_FIN;
            w_done_nx  = 1'b1;
          end else begin
            w_num_nx      = num_pkts;
            w_rem_nx      = pkt_len[5:0];
            w_gap_nx      = gap;
            w_last_idx_nx = BEAT_W'((pkt_len - LEN_W'(1)) >> 6);
            w_busy_nx     = 1'b1;
            w_state_nx    = S_SEND;
            w_ld          = 1'b1;
            w_ld_idx      = 16'd0;
          end
        end
      end

      S_SEND: begin
        if (w_acc) begin
          w_bytes_nx = r_sent_bytes + 64'($countones(r_tx_keep));
          if (!r_tx_last) begin
            w_ld      = 1'b1;
            w_ld_beat = r_beat + BEAT_W'(1);
          end else begin
            w_pkts_nx = r_sent_pkts + 32'd1;
            if (w_end) begin
              w_state_nx = S_FIN;
              w_done_nx  = 1'b1;
              w_busy_nx  = 1'b0;
              w_valid_nx = 1'b0;
              w_last_nx  = 1'b0;
              w_keep_nx  = '0;
              w_data_nx  = '0;
            end else if (r_gap == '0) begin
              // Back-to-back: next packet's first beat directly
              w_ld     = 1'b1;
              w_ld_idx = w_pkts_nx[15:0];
            end else begin
              w_state_nx   = S_GAP;
              w_gap_cnt_nx = r_gap;
              w_valid_nx   = 1'b0;
              w_last_nx    = 1'b0;
              w_keep_nx    = '0;
              w_data_nx    = '0;
            end
          end
        end
      end

      S_GAP: begin
        if (stop) begin
          w_state_nx = S_FIN;
          w_done_nx  = 1'b1;
          w_busy_nx  = 1'b0;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nx = S_SEND;
          w_ld       = 1'b1;
        end else begin
          w_gap_cnt_nx = r_gap_cnt - GAP_W'(1);
        end
      end

      S_FIN: w_state_nx = S_IDLE;

      default: w_state_nx = S_IDLE;
    endcase

    // Present a new beat; beat 0 always marks a packet start
    if (w_ld) begin
      w_valid_nx = 1'b1;
      w_beat_nx  = w_ld_beat;
      w_last_nx  = (w_ld_beat == w_last_idx_nx);
      w_keep_nx  = keep_for(w_ld_beat, w_last_idx_nx, w_rem_nx);
`ifdef STREAM_PKT_GEN_LFSR_EN
      w_lfsr_nx  = (w_ld_beat == '0) ? lfsr_seed(w_ld_idx) : lfsr_adv(r_lfsr);
      w_data_nx  = mask_bytes(w_lfsr_nx, w_keep_nx);
`else
      w_data_nx  = mask_bytes(count_pat(w_ld_idx, w_ld_beat), w_keep_nx);
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_num_pkts   <= '0;
      r_rem        <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_last_idx   <= '0;
      r_beat       <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_keep    <= '0;
      r_tx_last    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sent_pkts  <= '0;
      r_sent_bytes <= '0;
`ifdef STREAM_PKT_GEN_LFSR_EN
      r_lfsr       <= '0;
`endif
    end else begin
      r_state      <= w_state_nx;
      r_num_pkts   <= w_num_nx;
      r_rem        <= w_rem_nx;
      r_gap        <= w_gap_nx;
      r_gap_cnt    <= w_gap_cnt_nx;
      r_last_idx   <= w_last_idx_nx;
      r_beat       <= w_beat_nx;
      r_tx_valid   <= w_valid_nx;
      r_tx_data    <= w_data_nx;
      r_tx_keep    <= w_keep_nx;
      r_tx_last    <= w_last_nx;
      r_busy       <= w_busy_nx;
      r_done       <= w_done_nx;
      r_sent_pkts  <= w_pkts_nx;
      r_sent_bytes <= w_bytes_nx;
`ifdef STREAM_PKT_GEN_LFSR_EN
      r_lfsr       <= w_lfsr_nx;
`endif
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign tx_keep    = r_tx_keep;
  assign tx_last    = r_tx_last;
  assign busy       = r_busy;
  assign done       = r_done;
  assign sent_pkts  = r_sent_pkts;
  assign sent_bytes = r_sent_bytes;

endmodule

// File: tb/tb_stream_pkt_gen.sv
// Scoreboard bench for stream_pkt_gen (counting-pattern build).
module tb_stream_pkt_gen;

  logic         clk = 1'b0;
  logic         rst, start, stop, tx_ready;
  logic [31:0]  num_pkts;
  logic [15:0]  pkt_len;
  logic [7:0]   gap;
  logic         tx_valid, tx_last, busy, done;
  logic [511:0] tx_data;
  logic [63:0]  tx_keep;
  logic [31:0]  sent_pkts;
  logic [63:0]  sent_bytes;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int    acc_cyc[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  int    done_cnt = 0;
  int    done_cyc = -1;
  int    start_cyc = 0;
  bit    sim_end = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num_pkts(num_pkts), .pkt_len(pkt_len), .gap(gap),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_keep(tx_keep),
    .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .done(done), .sent_pkts(sent_pkts), .sent_bytes(sent_bytes)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Expected beats of one packet: lane i = {idx, beat, i}, bytes outside keep zero
  task automatic push_pkt(input int idx, input int len);
    beat_t e;
    int nb, rem;
    logic [15:0] idx16;
    logic [11:0] b12;
    logic [3:0]  l4;
    nb = (len + 63) / 64;
    idx16 = 16'(idx);
    for (int b = 0; b < nb; b++) begin
      rem = len - b * 64;
      e.keep = (rem >= 64) ? {64{1'b1}} : ((64'd1 << rem) - 64'd1);
      e.last = (b == nb - 1);
      b12 = 12'(b);
      for (int i = 0; i < 16; i++) begin
        l4 = 4'(i);
        e.data[i*32 +: 32] = {idx16, b12, l4};
      end
      for (int k = 0; k < 64; k++)
        if (!e.keep[k]) e.data[k*8 +: 8] = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input int n, input int len, input int g);
    num_pkts = 32'(n);
    pkt_len  = 16'(len);
    gap      = 8'(g);
    start    = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit rnd);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (rnd) tx_ready = ($urandom_range(0, 1) == 1);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    tx_ready = 1'b1;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat, checks hold under stall
  task automatic monitor();
    beat_t e;
    logic [576:0] cur, prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    while (!sim_end) begin
      @(negedge clk);
      cur = {tx_data, tx_keep, tx_last};
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (!tx_valid || cur !== prev) begin
            n_bad++;
            $display("FAIL hold_stable cyc=%0d valid=%0b last=%0b want %0b keep=%h want %h",
                     cyc, tx_valid, tx_last, prev[0], tx_keep, prev[64:1]);
          end
        end
        if (tx_valid && tx_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_beat cyc=%0d keep=%h last=%0b", cyc, tx_keep, tx_last);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e.data || tx_keep !== e.keep || tx_last !== e.last) begin
              n_bad++;
              $display("FAIL beat cyc=%0d last %0b want %0b keep %h want %h data %h want %h",
                       cyc, tx_last, e.last, tx_keep, e.keep, tx_data, e.data);
            end
          end
          acc_cyc.push_back(cyc);
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("busy_low_at_done", 64'(busy), 64'd0);
        end
        prev_stall = tx_valid && !tx_ready;
        prev = cur;
      end
    end
  endtask

  task automatic stimulus();
    rst = 1'b1; start = 1'b0; stop = 1'b0; tx_ready = 1'b1;
    num_pkts = '0; pkt_len = '0; gap = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_last", 64'(tx_last), 64'd0);
    chk("rst_keep", tx_keep, 64'd0);
    chk("rst_data_nonzero", 64'(tx_data != '0), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pkts", 64'(sent_pkts), 64'd0);
    chk("rst_bytes", sent_bytes, 64'd0);

    // 4 x 128 B back-to-back
    acc_cyc.delete();
    for (int p = 0; p < 4; p++) push_pkt(p, 128);
    do_start(4, 128, 0);
    wait_done("t1", 100, 1'b0);
    chk("t1_beats", 64'(acc_cyc.size()), 64'd8);
    if (acc_cyc.size() >= 8) begin
      chk("t1_latency", 64'(acc_cyc[0]), 64'(start_cyc + 1));
      chk("t1_contiguous", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
      chk("t1_done_cycle", 64'(done_cyc), 64'(acc_cyc[7] + 1));
    end
    chk("t1_pkts", 64'(sent_pkts), 64'd4);
    chk("t1_bytes", sent_bytes, 64'd512);
    chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // 2 x 65 B with 3-cycle gap
    acc_cyc.delete();
    for (int p = 0; p < 2; p++) push_pkt(p, 65);
    do_start(2, 65, 3);
    wait_done("t2", 100, 1'b0);
    chk("t2_beats", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() >= 4) begin
      chk("t2_intra_pkt", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
      chk("t2_gap_span", 64'(acc_cyc[2] - acc_cyc[1]), 64'd4);
    end
    chk("t2_pkts", 64'(sent_pkts), 64'd2);
    chk("t2_bytes", sent_bytes, 64'd130);
    chk("t2_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // 3 x 100 B, gap 1, random backpressure
    acc_cyc.delete();
    for (int p = 0; p < 3; p++) push_pkt(p, 100);
    do_start(3, 100, 1);
    wait_done("t3", 400, 1'b1);
    chk("t3_beats", 64'(acc_cyc.size()), 64'd6);
    chk("t3_pkts", 64'(sent_pkts), 64'd3);
    chk("t3_bytes", sent_bytes, 64'd300);
    chk("t3_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Unbounded run, stop raised while packet 10 is stalled
    acc_cyc.delete();
    for (int p = 0; p < 11; p++) push_pkt(p, 64);
    do_start(0, 64, 0);
    for (int k = 0; k < 50; k++) begin
      if (acc_cyc.size() >= 10) break;
      @(posedge clk); #1;
    end
    chk("t4_reached_pkt10", 64'(acc_cyc.size()), 64'd10);
    tx_ready = 1'b0;
    stop = 1'b1;
    repeat (3) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done("t4", 50, 1'b0);
    stop = 1'b0;
    chk("t4_pkts", 64'(sent_pkts), 64'd11);
    chk("t4_bytes", sent_bytes, 64'd704);
    chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset during packet 2, then a clean restart
    acc_cyc.delete();
    for (int p = 0; p < 5; p++) push_pkt(p, 128);
    do_start(5, 128, 0);
    for (int k = 0; k < 50; k++) begin
      if (acc_cyc.size() >= 5) break;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_valid", 64'(tx_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_pkts", 64'(sent_pkts), 64'd0);
    chk("t5_bytes", sent_bytes, 64'd0);
    exp_q.delete();
    acc_cyc.delete();
    push_pkt(0, 64);
    do_start(1, 64, 0);
    wait_done("t5b", 50, 1'b0);
    chk("t5b_pkts", 64'(sent_pkts), 64'd1);
    chk("t5b_bytes", sent_bytes, 64'd64);
    chk("t5b_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Zero length: no beats, done next cycle
    acc_cyc.delete();
    do_start(3, 0, 0);
    wait_done("t6", 20, 1'b0);
    chk("t6_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
    chk("t6_beats", 64'(acc_cyc.size()), 64'd0);
    chk("t6_pkts", 64'(sent_pkts), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // Start while busy must not disturb the latched config
    acc_cyc.delete();
    push_pkt(0, 128);
    tx_ready = 1'b0;
    do_start(1, 128, 0);
    chk("t6b_busy", 64'(busy), 64'd1);
    do_start(3, 64, 0);
    repeat (2) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done("t6b", 50, 1'b0);
    chk("t6b_beats", 64'(acc_cyc.size()), 64'd2);
    chk("t6b_pkts", 64'(sent_pkts), 64'd1);
    chk("t6b_bytes", sent_bytes, 64'd128);
    chk("t6b_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    sim_end = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_pkt_gen.md
Name: stream_pkt_gen

Overview:
- Synthesizable AXI-Stream packet transmitter. It is the source-side counterpart to the stream performance monitor.
- Emits a programmed number of fixed-length packets on a 512-bit stream with byte-accurate keep and last.
- Inserts a configurable idle gap between packets and honours backpressure.
- Reports transmitted packet and byte totals for throughput cross-checks in sim and on FPGA.

Parameters:
- DATA_W, 512, stream data width in bits; keep width is DATA_W/8. Only 512 is supported.
- LEN_W, 16, width of the packet length field in bytes.
- GAP_W, 8, width of the inter-packet gap field in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; latches config and begins a run; ignored while busy
- stop  in  1  level; ends the run at the next packet boundary
- num_pkts  in  32  packets per run; 0 = run until stop
- pkt_len  in  LEN_W  packet length in bytes
- gap  in  GAP_W  idle cycles between packets
- tx_valid  out  1  stream valid
- tx_data  out  DATA_W  stream data
- tx_keep  out  64  byte enables
- tx_last  out  1  final beat of packet
- tx_ready  in  1  sink ready
- busy  out  1  run in progress
- done  out  1  single-cycle pulse at end of run
- sent_pkts  out  32  packets completed this run
- sent_bytes  out  64  bytes completed this run (sum of popcount(keep) over accepted beats)

Behaviour:
- Reset values: tx_valid=0, tx_last=0, tx_keep=0, tx_data=0, busy=0, done=0, sent_pkts=0, sent_bytes=0, FSM=IDLE.
- Reset mid-packet abandons the packet immediately; no partial last is emitted.
- FSM states: IDLE, SEND, GAP, FIN.
- IDLE, start=1:
  - pkt_len==0: go to FIN and emit no beats.
  - otherwise: latch num_pkts, pkt_len and gap; clear the counters; set busy; go to SEND.
  - First tx_valid is asserted the cycle after start (latency 1).
- Beats per packet = ceil(pkt_len/64).
  - Non-last beats: keep=all ones.
  - Last beat: keep = low (pkt_len mod 64) bits set, or all ones if mod=0.
  - tx_last=1 only on the last beat.
- Handshake: a beat is accepted when tx_valid&tx_ready.
  - While valid and not ready, tx_data, tx_keep and tx_last are held stable.
  - tx_valid is never deasserted before acceptance.
- On each accepted beat: sent_bytes += popcount(tx_keep).
- On an accepted last beat: sent_pkts += 1, then evaluate the end condition:
  - end condition is (num_pkts!=0 and sent_pkts+1==num_pkts) or stop=1.
  - end condition true: go to FIN.
  - else gap==0: stay in SEND and drive the next packet's first beat the next cycle (back-to-back).
  - else: go to GAP.
- GAP: tx_valid=0 for exactly gap cycles, then SEND.
  - stop sampled in GAP goes to FIN on that cycle.
- stop asserted mid-packet never truncates; the current packet completes.
- FIN: one cycle with done=1; busy drops in the same cycle; return to IDLE. Counters hold until the next start.
- Payload (default): 32-bit lane i (0..15) of beat b = {pkt_idx[15:0], b[11:0], i[3:0]}.
  - pkt_idx is the 0-based packet number within the run.
  - Bytes outside keep are driven 0.
- Widths:
  - sent_pkts wraps at 2^32.
  - The internal beat counter is LEN_W-6+1 bits.
  - sent_bytes is 64 bits and does not overflow in practice.
- start while busy: ignored; no config change.
- start and stop together in IDLE: the run starts, sends one packet, then ends.

Optional Feature:
- STREAM_PKT_GEN_LFSR_EN defined:
  - Payload comes from a 32-bit Galois LFSR (poly 0x80200003), one instance per lane.
  - Lane i is seeded at packet start with {pkt_idx[15:0], 12'h0, i[3:0]} ^ 32'hA5A5A5A5.
  - Each LFSR advances once per accepted beat.
- Not defined: counting pattern above; no LFSR logic is synthesized.
- Keep, last, handshake and counters are identical in both builds.

Test Plan:
- num_pkts=4, pkt_len=128, gap=0, tx_ready=1 -> 8 contiguous valid beats; last on beats 2,4,6,8; keep all ones; done one cycle after the 8th beat; sent_pkts=4, sent_bytes=512.
- num_pkts=2, pkt_len=65, gap=3 -> per packet a full beat then a beat with keep=64'h1 and last; exactly 3 invalid cycles between packets; sent_bytes=130.
- pkt_len=100, tx_ready toggled pseudo-randomly -> data/keep/last stable while valid&!ready; no dropped or duplicated beats; payload lane fields match {pkt_idx,beat,lane}.
- num_pkts=0, pkt_len=64; assert stop mid-packet 10 -> packet 10 completes with last; done pulses; sent_pkts=11.
- rst asserted mid-beat of packet 2 -> next cycle tx_valid=0, busy=0, counters 0; a subsequent start begins cleanly with pkt_idx=0.
- pkt_len=0 start -> no valid beats; done pulses next cycle; sent_pkts=0; start while busy has no effect on the latched config.
